// File: rtl/audio_pkg.sv
// Shared constants for the tone-to-I2S audio back end: widths, divider taps
// and the frame load point.
package audio_pkg;

  localparam int DIV_W    = 22;
  localparam int SAMPLE_W = 16;
  localparam int DCNT_W   = 9;

  localparam int MCLK_BIT = 1;
  localparam int SCK_BIT  = 3;
  localparam int LRCK_BIT = 8;

  localparam logic [DCNT_W-1:0] FRAME_LOAD_CNT = 9'd15;

  // The same sample is sent on both channels of a frame.
  function automatic logic [2*SAMPLE_W-1:0] stereo_word(input logic [SAMPLE_W-1:0] s);
    return {s, s};
  endfunction

endpackage

// File: rtl/tone_i2s_out_note_gen.sv
// Square-wave tone generator: half-period counter, phase bit and the
// volume select that forms the current sample.
module note_gen #(
  parameter int DIV_W    = audio_pkg::DIV_W,
  parameter int SAMPLE_W = audio_pkg::SAMPLE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DIV_W-1:0]    note_div,
  input  logic [SAMPLE_W-1:0] vol,
  input  logic [SAMPLE_W-1:0] vol_minus,
  output logic [SAMPLE_W-1:0] sample
);

  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] tcnt_q, tcnt_d;
  logic             phase_q, phase_d;
  logic [DIV_W-1:0] note_div_q, note_div_d;

  // A note change outranks a same-cycle wrap, so phase restarts low.
  always_comb begin
    tcnt_d     = tcnt_q;
    phase_d    = phase_q;
    note_div_d = note_div;
    if (note_div == DIV_ZERO) begin
      tcnt_d  = DIV_ZERO;
      phase_d = 1'b0;
    end else if (note_div != note_div_q) begin
      tcnt_d  = DIV_ZERO;
      phase_d = 1'b0;
    end else if (tcnt_q == (note_div - DIV_ONE)) begin
      tcnt_d  = DIV_ZERO;
      phase_d = ~phase_q;
    end else begin
      tcnt_d  = tcnt_q + DIV_ONE;
      phase_d = phase_q;
    end
  end

  // Tone state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q     <= DIV_ZERO;
      phase_q    <= 1'b0;
      note_div_q <= DIV_ZERO;
    end else begin
      tcnt_q     <= tcnt_d;
      phase_q    <= phase_d;
      note_div_q <= note_div_d;
    end
  end

  // Silence is forced directly so a stale phase never leaks out.
  assign sample = (note_div == DIV_ZERO) ? {SAMPLE_W{1'b0}}
                                         : (phase_q ? vol : vol_minus);

endmodule

// File: rtl/tone_i2s_out.sv
// Tone back end: frame clock divider plus 32-bit I2S serialiser fed by
// the note generator.
module tone_i2s_out #(
  parameter int DIV_W    = audio_pkg::DIV_W,
  parameter int SAMPLE_W = audio_pkg::SAMPLE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DIV_W-1:0]    note_div,
  input  logic [SAMPLE_W-1:0] vol,
  input  logic [SAMPLE_W-1:0] vol_minus,
  output logic                audio_mclk,
  output logic                audio_sck,
  output logic                audio_lrck,
  output logic                audio_sdin
);

  import audio_pkg::*;

  localparam int SR_W = 2 * SAMPLE_W;

  logic [SAMPLE_W-1:0] sample;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic [SR_W-1:0]     shreg_q, shreg_d;

  note_gen #(
    .DIV_W    (DIV_W),
    .SAMPLE_W (SAMPLE_W)
  ) u_gen (
    .clk       (clk),
    .rst       (rst),
    .note_div  (note_div),
    .vol       (vol),
    .vol_minus (vol_minus),
    .sample    (sample)
  );

  // Shift on every SCK fall; the slot-0 fall reloads instead, giving the one-bit I2S delay.
  always_comb begin
    dcnt_d  = dcnt_q + 9'd1;
    shreg_d = shreg_q;
    if (dcnt_q == FRAME_LOAD_CNT) begin
      shreg_d = stereo_word(sample);
    end else if (dcnt_q[SCK_BIT:0] == {(SCK_BIT+1){1'b1}}) begin
      shreg_d = shreg_q << 1;
    end else begin
      shreg_d = shreg_q;
    end
  end

  // Divider and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt_q  <= {DCNT_W{1'b0}};
      shreg_q <= {SR_W{1'b0}};
    end else begin
      dcnt_q  <= dcnt_d;
      shreg_q <= shreg_d;
    end
  end

  assign audio_mclk = dcnt_q[MCLK_BIT];
  assign audio_sck  = dcnt_q[SCK_BIT];
  assign audio_lrck = dcnt_q[LRCK_BIT];
  assign audio_sdin = shreg_q[SR_W-1];

endmodule
